// File: rtl/ili9341_pkg.sv
// Shared definitions for the ILI9341 frame streamer: FSM state encoding and
// the geometry helpers used to size the pixel counter and ROM address bus.
package ili9341_pkg;

    // Streamer FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    // Ceiling log2 that never returns a zero width, so degenerate geometries
    // (a single pixel or a single frame) still produce a legal vector.
    function automatic int clog2_min1(input int value);
        int width;
        width = $clog2(value);
        return (width < 1) ? 1 : width;
    endfunction

    // Number of pixels in one image.
    function automatic int frame_pixels(input int h_res, input int v_res);
        return h_res * v_res;
    endfunction

    // Width of the pixel counter inside one frame.
    function automatic int pix_width(input int h_res, input int v_res);
        return clog2_min1(h_res * v_res);
    endfunction

    // Width of the address bus covering every image stored in the ROM.
    function automatic int addr_width(input int h_res, input int v_res, input int num_frames);
        return clog2_min1(h_res * v_res * num_frames);
    endfunction

    // Frame selector width; one extra bit so out-of-range selections exist.
    function automatic int sel_width(input int num_frames);
        return $clog2(num_frames) + 1;
    endfunction

endpackage

// File: rtl/ili9341_frame_streamer.sv
// Streams one image out of an external pixel ROM towards an ILI9341 display
// controller using a valid/ready handshake. Images are stored back-to-back in
// the ROM; an out-of-range selection streams a full frame of background colour.
// The ROM is synchronous: an address presented during READ returns its word
// during WAIT, where it is captured into pixel_data.
module ili9341_frame_streamer
    import ili9341_pkg::*;
#(
    parameter int H_RES      = 128,
    parameter int V_RES      = 128,
    parameter int PIXEL_SIZE = 16,
    parameter int NUM_FRAMES = 4,
    parameter logic [PIXEL_SIZE-1:0] BG_COLOR = '0,
    localparam int FRAME_PIX = frame_pixels(H_RES, V_RES),
    localparam int PIX_W     = pix_width(H_RES, V_RES),
    localparam int SEL_W     = sel_width(NUM_FRAMES),
    localparam int ADDR_W    = addr_width(H_RES, V_RES, NUM_FRAMES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SEL_W-1:0]      frame_sel,
    input  logic                  refresh_req,
    input  logic                  continuous,
    output logic [ADDR_W-1:0]     rom_addr,
    input  logic [PIXEL_SIZE-1:0] rom_data,
    output logic [PIXEL_SIZE-1:0] pixel_data,
    output logic                  pixel_valid,
    input  logic                  pixel_ready,
    output logic                  frame_start,
    output logic                  frame_done,
    output logic                  busy
);

    localparam logic [PIX_W-1:0]  LAST_PIX     = PIX_W'(FRAME_PIX - 1);
    localparam logic [SEL_W-1:0]  NUM_FRAMES_S = SEL_W'(NUM_FRAMES);
    localparam logic [ADDR_W-1:0] FRAME_PIX_A  = ADDR_W'(FRAME_PIX);

    logic [1:0]        state;
    logic [PIX_W-1:0]  pix_cnt;
    logic [SEL_W-1:0]  sel_q;
    logic              pending;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] read_addr;
    logic              sel_valid;
    logic              start_frame;
    logic              accept;
    logic              last_pix;

    // Address generation and handshake decode; the ROM address only moves in
    // READ for a valid image and otherwise replays the last issued address.
    always_comb begin
        sel_valid   = (sel_q < NUM_FRAMES_S);
        read_addr   = ADDR_W'(sel_q) * FRAME_PIX_A + ADDR_W'(pix_cnt);
        rom_addr    = addr_q;
        if (state == ST_READ && sel_valid) begin
            rom_addr = read_addr;
        end
        start_frame = (state == ST_IDLE) && (refresh_req || pending || continuous);
        accept      = (state == ST_HOLD) && pixel_ready;
        last_pix    = (pix_cnt == LAST_PIX);
    end

    // Remember the last address driven so it can be held outside READ.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
        end else begin
            addr_q <= rom_addr;
        end
    end

    // One-deep request memory: any number of requests during a frame collapse
    // into a single follow-up frame, consumed by the frame start it causes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= 1'b0;
        end else if (start_frame) begin
            pending <= 1'b0;
        end else if (refresh_req && state != ST_IDLE) begin
            pending <= 1'b1;
        end
    end

    // Main sequencer: READ issues the address, WAIT captures ROM data, HOLD
    // keeps the pixel steady until the controller takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            pix_cnt     <= '0;
            sel_q       <= '0;
            pixel_data  <= '0;
            pixel_valid <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_frame) begin
                        sel_q       <= frame_sel;
                        pix_cnt     <= '0;
                        frame_start <= 1'b1;
                        busy        <= 1'b1;
                        state       <= ST_READ;
                    end
                end
                ST_READ: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    pixel_data  <= sel_valid ? rom_data : BG_COLOR;
                    pixel_valid <= 1'b1;
                    state       <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (accept) begin
                        pixel_valid <= 1'b0;
                        if (last_pix) begin
                            pix_cnt    <= '0;
                            frame_done <= 1'b1;
                            busy       <= 1'b0;
                            state      <= ST_IDLE;
                        end else begin
                            pix_cnt <= pix_cnt + 1'b1;
                            state   <= ST_READ;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ili9341_frame_streamer.sv
// Self-checking bench for ili9341_frame_streamer on a tiny 4x2, two-image
// geometry. A behavioural ROM feeds the DUT; accepted pixels are collected and
// compared against the image contents implied by the selected frame.
module tb_ili9341_frame_streamer;

    localparam int H_RES      = 4;
    localparam int V_RES      = 2;
    localparam int NUM_FRAMES = 2;
    localparam int FRAME_PIX  = H_RES * V_RES;
    localparam int SEL_W      = 2;
    localparam int ADDR_W     = 4;
    localparam logic [15:0] BG = 16'hA5A5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [SEL_W-1:0]  frame_sel = '0;
    logic              refresh_req = 1'b0;
    logic              continuous = 1'b0;
    logic [ADDR_W-1:0] rom_addr;
    logic [15:0]       rom_data = '0;
    logic [15:0]       pixel_data;
    logic              pixel_valid;
    logic              pixel_ready = 1'b1;
    logic              frame_start;
    logic              frame_done;
    logic              busy;

    logic [15:0] rom [FRAME_PIX*NUM_FRAMES];
    logic [15:0] acc_q [$];
    bit          ready_rand = 1'b0;
    int          vectors = 0;
    int          miscompares = 0;
    int          fs_cnt = 0;
    int          fd_cnt = 0;
    int          since_start = 0;
    bit          lat_pending = 1'b0;
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic [15:0] prev_data = '0;

    ili9341_frame_streamer #(
        .H_RES(H_RES), .V_RES(V_RES), .PIXEL_SIZE(16),
        .NUM_FRAMES(NUM_FRAMES), .BG_COLOR(BG)
    ) dut (
        .clk(clk), .rst(rst), .frame_sel(frame_sel), .refresh_req(refresh_req),
        .continuous(continuous), .rom_addr(rom_addr), .rom_data(rom_data),
        .pixel_data(pixel_data), .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
        .frame_start(frame_start), .frame_done(frame_done), .busy(busy)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Synchronous ROM with one cycle of read latency
    always @(posedge clk) rom_data <= rom[rom_addr];

    // Controller back-pressure: always ready, or a coin toss per cycle
    initial begin
        forever begin
            @(posedge clk);
            #1;
            pixel_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Hard stop in case something never terminates
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Reference image content: word i of image sel, or background when the
    // selection does not name a stored image.
    function automatic logic [15:0] expectedPixel(input int sel, input int i);
        if (sel < NUM_FRAMES) return rom[sel*FRAME_PIX + i];
        return BG;
    endfunction

    // Mid-cycle monitor: counts frame pulses, records accepted pixels, checks
    // first-pixel latency and that a stalled pixel does not change.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid  = 1'b0;
            prev_ready  = 1'b0;
            lat_pending = 1'b0;
        end else begin
            if (frame_start) begin
                fs_cnt++;
                since_start = 0;
                lat_pending = 1'b1;
            end else begin
                since_start++;
            end
            if (lat_pending && pixel_valid) begin
                checkOutput("first_pixel_latency", since_start, 2);
                lat_pending = 1'b0;
            end
            if (prev_valid && !prev_ready) begin
                checkOutput("stall_valid", pixel_valid, 1);
                checkOutput("stall_data", pixel_data, prev_data);
            end
            if (pixel_valid && pixel_ready) acc_q.push_back(pixel_data);
            if (frame_done) fd_cnt++;
            prev_valid = pixel_valid;
            prev_ready = pixel_ready;
            prev_data  = pixel_data;
        end
    end

    task automatic waitFrames(input int target, input int limit);
        int n = 0;
        while (fd_cnt < target && n < limit) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (fd_cnt < target) checkOutput("frame_done_timeout", fd_cnt, target);
    endtask

    task automatic waitPixels(input int target, input int limit);
        int n = 0;
        while (acc_q.size() < target && n < limit) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (acc_q.size() < target) checkOutput("pixel_timeout", acc_q.size(), target);
    endtask

    task automatic checkFrame(input int sel, input int offset);
        for (int i = 0; i < FRAME_PIX; i++) begin
            if (offset + i < acc_q.size())
                checkOutput("pixel", acc_q[offset+i], expectedPixel(sel, i));
        end
    endtask

    task automatic pulseRefresh();
        @(posedge clk);
        #1;
        refresh_req = 1'b1;
        @(posedge clk);
        #1;
        refresh_req = 1'b0;
    endtask

    // Stream one requested frame and compare it with the reference image
    task automatic applyStimulus(input int sel, input bit rand_ready);
        int fs0, fd0;
        logic [ADDR_W-1:0] addr0;
        @(posedge clk);
        #1;
        frame_sel  = SEL_W'(sel);
        ready_rand = rand_ready;
        acc_q.delete();
        fs0   = fs_cnt;
        fd0   = fd_cnt;
        addr0 = rom_addr;
        pulseRefresh();
        waitFrames(fd0 + 1, 400);
        repeat (5) @(negedge clk);
        #1;
        checkOutput("frame_start_count", fs_cnt - fs0, 1);
        checkOutput("frame_done_count", fd_cnt - fd0, 1);
        checkOutput("pixel_count", acc_q.size(), FRAME_PIX);
        checkFrame(sel, 0);
        checkOutput("busy_after", busy, 0);
        if (sel < NUM_FRAMES) checkOutput("last_addr", rom_addr, sel*FRAME_PIX + FRAME_PIX - 1);
        else                  checkOutput("held_addr", rom_addr, addr0);
    endtask

    initial begin
        int fs0, fd0, sel;
        for (int i = 0; i < FRAME_PIX*NUM_FRAMES; i++)
            rom[i] = {4'(i), 12'($urandom_range(0, 4095))};

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("reset_rom_addr", rom_addr, 0);
        checkOutput("reset_pixel_data", pixel_data, 0);
        checkOutput("reset_pixel_valid", pixel_valid, 0);
        checkOutput("reset_frame_start", frame_start, 0);
        checkOutput("reset_frame_done", frame_done, 0);
        checkOutput("reset_busy", busy, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Image 1 with the controller always ready, then image 0 with stalls
        applyStimulus(1, 1'b0);
        applyStimulus(0, 1'b1);
        // Out-of-range selection streams background
        applyStimulus(3, 1'b1);

        // Repeated requests during a frame collapse into one extra frame; the
        // selection change only applies to that follow-up frame
        frame_sel  = 2'd0;
        ready_rand = 1'b1;
        acc_q.delete();
        fs0 = fs_cnt;
        fd0 = fd_cnt;
        pulseRefresh();
        waitPixels(3, 200);
        frame_sel = 2'd1;
        repeat (3) pulseRefresh();
        waitFrames(fd0 + 2, 600);
        repeat (20) @(negedge clk);
        #1;
        checkOutput("pending_frame_starts", fs_cnt - fs0, 2);
        checkOutput("pending_frame_dones", fd_cnt - fd0, 2);
        checkOutput("pending_pixel_count", acc_q.size(), 2*FRAME_PIX);
        checkFrame(0, 0);
        checkFrame(1, FRAME_PIX);
        checkOutput("pending_busy_after", busy, 0);

        // Continuous mode dropped part-way through the third frame
        sel = $urandom_range(0, 1);
        @(posedge clk);
        #1;
        frame_sel  = SEL_W'(sel);
        ready_rand = 1'b0;
        acc_q.delete();
        fs0 = fs_cnt;
        fd0 = fd_cnt;
        continuous = 1'b1;
        waitPixels(2*FRAME_PIX + FRAME_PIX/2, 300);
        @(posedge clk);
        #1;
        continuous = 1'b0;
        waitFrames(fd0 + 3, 300);
        repeat (20) @(negedge clk);
        #1;
        checkOutput("cont_frame_starts", fs_cnt - fs0, 3);
        checkOutput("cont_frame_dones", fd_cnt - fd0, 3);
        checkOutput("cont_pixel_count", acc_q.size(), 3*FRAME_PIX);
        for (int f = 0; f < 3; f++) checkFrame(sel, f*FRAME_PIX);
        checkOutput("cont_busy_after", busy, 0);

        // Randomised single frames, including out-of-range selections
        repeat (4) applyStimulus($urandom_range(0, 3), 1'b1);

        // Reset while the sixth pixel is in flight aborts the frame
        frame_sel  = 2'd0;
        ready_rand = 1'b0;
        acc_q.delete();
        fs0 = fs_cnt;
        fd0 = fd_cnt;
        pulseRefresh();
        waitPixels(5, 200);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("abort_rom_addr", rom_addr, 0);
        checkOutput("abort_pixel_data", pixel_data, 0);
        checkOutput("abort_pixel_valid", pixel_valid, 0);
        checkOutput("abort_frame_start", frame_start, 0);
        checkOutput("abort_frame_done", frame_done, 0);
        checkOutput("abort_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        checkOutput("abort_no_done", fd_cnt - fd0, 0);
        checkOutput("abort_no_restart", fs_cnt - fs0, 1);
        checkOutput("abort_idle_busy", busy, 0);
        checkOutput("abort_idle_valid", pixel_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
